// File: rtl/fetch_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch unit.
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE    = 3'd0;
  localparam fetch_state_t ST_REQ     = 3'd1;
  localparam fetch_state_t ST_HOLD    = 3'd2;
  localparam fetch_state_t ST_DISCARD = 3'd3;
  localparam fetch_state_t ST_ERR     = 3'd4;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory-wait watchdog: counts consecutive waiting cycles and flags expiry on the last allowed one.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !waiting) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

  // Expiry fires during the cycle that would make the count reach TIMEOUT_CYCLES.
  assign expired = waiting && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads bytes at the PC, hands them to control, flushes on branch.
// Defining FETCH_TIMEOUT_EN adds a memory-wait watchdog driving a sticky fetch_err.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               BRANCH,
  output logic               PCI,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               fetch_err
);

  fetch_state_t      state;
  logic              req_first;
  logic [ADDR_W-1:0] addr_q;
  logic              expire;

`ifdef FETCH_TIMEOUT_EN
  logic waiting;

  assign waiting = ((state == ST_REQ) || (state == ST_DISCARD)) && !mem_ack;

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (RST),
    .waiting (waiting),
    .expired (expire)
  );

  assign fetch_err = (state == ST_ERR);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign expire             = 1'b0;
  assign fetch_err          = 1'b0;
`endif

  // The first REQ cycle follows pc_addr live so a PC loaded by the branch edge is picked up.
  assign mem_req  = (state == ST_REQ) || (state == ST_DISCARD);
  assign mem_addr = ((state == ST_REQ) && req_first) ? pc_addr : addr_q;
  assign PCI      = (state == ST_REQ) && mem_ack && !BRANCH;

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= ST_IDLE;
      req_first <= 1'b0;
      addr_q    <= '0;
      ir_out    <= '0;
      ir_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_REQ;
          req_first <= 1'b1;
        end
        ST_REQ: begin
          if (req_first) begin
            addr_q <= pc_addr;
          end
          req_first <= 1'b0;
          if (expire) begin
            state <= ST_ERR;
          end else if (mem_ack && !BRANCH) begin
            ir_out   <= mem_data;
            ir_valid <= 1'b1;
            state    <= ST_HOLD;
          end else if (mem_ack) begin
            state     <= ST_REQ;
            req_first <= 1'b1;
          end else if (BRANCH) begin
            state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (expire) begin
            state <= ST_ERR;
          end else if (mem_ack) begin
            state     <= ST_REQ;
            req_first <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (BRANCH || ir_ready) begin
            ir_valid  <= 1'b0;
            state     <= ST_REQ;
            req_first <= 1'b1;
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the memory-wait cycles before a fetch error (used only with FETCH_TIMEOUT_EN).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 pc_addr  input  8  SHALL be the current program-counter value (PC addr_out).
REQ-005 BRANCH  input  1  SHALL be the same branch strobe that loads the PC; flush request.
REQ-006 PCI  output  1  SHALL be the one-cycle PC-increment pulse to the PC.
REQ-007 mem_req  output  1  SHALL be the instruction-memory read request.
REQ-008 mem_addr  output  8  SHALL be the read address, valid while mem_req=1.
REQ-009 mem_ack  input  1  SHALL be the memory acknowledge; mem_data is valid in the ack cycle.
REQ-010 mem_data  input  8  SHALL be the instruction byte from memory.
REQ-011 ir_out  output  8  SHALL be the fetched instruction to the control unit.
REQ-012 ir_valid / ir_ready  output / input  1 / 1  SHALL be the instruction handshake; transfer when both are 1.
REQ-013 fetch_err  output  1  SHALL be the sticky memory-timeout flag.

Function
REQ-014 FSM states SHALL be IDLE, REQ, HOLD, DISCARD, ERR.
- IDLE->REQ unconditionally on the next edge.
REQ-015 REQ SHALL drive mem_req=1 and mem_addr=pc_addr sampled on REQ entry, held stable until ack.
REQ-016 REQ with mem_ack=1 and BRANCH=0 SHALL, at that edge:
- load ir_out<=mem_data
- set ir_valid=1
- go to HOLD
REQ-017 PCI SHALL be 1 exactly in that ack cycle (combinational on ack, BRANCH=0), so pc_addr has advanced by the first HOLD cycle.
REQ-018 HOLD SHALL keep ir_out/ir_valid stable until ir_valid&ir_ready.
- Then ir_valid<=0 and REQ next cycle.
- Minimum issue-to-issue interval: 2 cycles after ack.
REQ-019 BRANCH=1 in HOLD SHALL drop ir_valid next cycle (instruction discarded even if ir_ready=1) and go to REQ; the new request uses the branched pc_addr.
REQ-020 BRANCH=1 in REQ without ack SHALL:
- keep mem_req asserted, same mem_addr
- go to DISCARD
REQ-021 DISCARD SHALL wait for mem_ack, drop the data (no ir_valid, no PCI), then go to REQ.
REQ-022 BRANCH=1 coincident with mem_ack in REQ SHALL:
- discard the data
- assert no PCI
- go to REQ
REQ-023 PCI SHALL never be 1 when BRANCH=1.
REQ-024 mem_ack outside REQ/DISCARD SHALL be ignored.
REQ-025 Address wrap SHALL be owned by the PC; 8'hFF followed by 8'h00 SHALL need no special handling.

Reset
REQ-026 RST=1 at an edge SHALL set:
- state=IDLE
- mem_req=0, mem_addr=0
- PCI=0
- ir_out=0, ir_valid=0
- fetch_err=0
- timeout counter=0
REQ-027 RST mid-request SHALL abandon the request; mem_req is 0 in the cycle after the reset edge.
REQ-028 The first mem_req SHALL assert 2 cycles after the last RST=1 edge (IDLE then REQ).

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined, a counter SHALL:
- count REQ/DISCARD cycles without ack
- clear on ack
- on reaching TIMEOUT_CYCLES: set fetch_err=1, drop mem_req, go to ERR
REQ-030 ERR SHALL persist until RST.
REQ-031 Without FETCH_TIMEOUT_EN:
- fetch_err SHALL be tied to 0
- ERR SHALL be unreachable
- the FSM SHALL wait indefinitely for ack

Structure
REQ-032 Package fetch_pkg SHALL hold:
- ADDR_W=8, INSTR_W=8
- the FSM state typedef/encoding
REQ-033 Sub-module fetch_timeout_ctr (counter plus compare) SHALL be instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-034 Reset release, pc_addr=8'h00, ack 1 cycle after req with data 8'hA5, ir_ready=1 -> ir_out=8'hA5, ir_valid 1 cycle, one PCI pulse, next mem_addr=8'h01.
REQ-035 ir_ready=0 for 5 cycles -> ir_out/ir_valid stable, no new mem_req, no extra PCI.
REQ-036 BRANCH in REQ (no ack), pc_addr goes to 8'h40, ack 3 cycles later -> data dropped, no PCI, next mem_addr=8'h40.
REQ-037 BRANCH coincident with ack, and separately BRANCH in HOLD -> no PCI, ir_valid low next cycle, refetch from the branch target.
REQ-038 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> fetch_err=1 after 4 cycles, mem_req=0, held until RST.
REQ-039 RST asserted during REQ -> all outputs 0 next cycle; fetch restarts at 8'h00.
